// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes six IRQ lines, latches edge sources, masks them and drives a registered HWInt.
// Latency IrqIn->HWInt is SYNC_STAGES+2 edges; bus is single-cycle with no backpressure, RData is combinational.
module int_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [5:0]  IrqIn,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [5:0]  HWInt
);

  logic [SYNC_STAGES-1:0][5:0] sync_r;
  logic [5:0] sync;
  logic [5:0] prev;
  logic [5:0] mode;
  logic [5:0] enable;
  logic [5:0] pending;
  logic [5:0] pending_nxt;
  logic [5:0] mode_chg;
  logic [5:0] w1c;
  logic [5:0] rise;
  logic [2:0] low_idx;
  logic       wr_mode;
  logic       wr_enable;
  logic       wr_pending;
  logic       wdata_unused;

  assign sync         = sync_r[SYNC_STAGES-1];
  assign wr_mode      = We && (Addr == 2'd0);
  assign wr_enable    = We && (Addr == 2'd1);
  assign wr_pending   = We && (Addr == 2'd2);
  assign wdata_unused = ^WData[31:6];

  // A mode flip wipes the source so a stale edge/level value never leaks across modes.
  assign mode_chg    = wr_mode ? (WData[5:0] ^ mode) : 6'h00;
  assign w1c         = wr_pending ? WData[5:0] : 6'h00;
  assign rise        = sync & ~prev;
  assign pending_nxt = ~mode_chg & ((mode & (rise | (pending & ~w1c))) | (~mode & sync));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_r  <= '0;
      prev    <= 6'h00;
      mode    <= 6'h00;
      enable  <= 6'h00;
      pending <= 6'h00;
      HWInt   <= 6'h00;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], IrqIn};
      prev    <= sync;
      pending <= pending_nxt;
      HWInt   <= pending & enable;
      if (wr_mode)   mode   <= WData[5:0];
      if (wr_enable) enable <= WData[5:0];
    end
  end

  always_comb begin
    low_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (HWInt[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    RData = 32'h0;
    case (Addr)
      2'd0: RData = {26'h0, mode};
      2'd1: RData = {26'h0, enable};
      2'd2: RData = {26'h0, pending};
      default: RData = {|HWInt, 28'h0, low_idx};
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus random traffic against a sample-history reference model.
module tb_int_ctrl;
  localparam int SYNC = 2;

  logic        Clk;
  logic        Rst;
  logic [5:0]  IrqIn;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] WData;
  logic [31:0] RData;
  logic [5:0]  HWInt;

  int total;
  int bad;

  // Reference state: raw samples of IrqIn taken at each edge, plus architectural registers.
  logic [5:0] hist[$];
  logic [5:0] m_mode;
  logic [5:0] m_en;
  logic [5:0] m_pend;
  logic [5:0] m_hw;

  int_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .Clk(Clk), .Rst(Rst), .IrqIn(IrqIn), .Addr(Addr), .We(We),
    .WData(WData), .RData(RData), .HWInt(HWInt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic m_reset();
    hist.delete();
    m_mode = 6'h00;
    m_en   = 6'h00;
    m_pend = 6'h00;
    m_hw   = 6'h00;
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [2:0] idx;
    logic       found;
    idx = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (m_hw[i] && !found) begin
        idx = 3'(i);
        found = 1'b1;
      end
    end
    case (a)
      2'd0: return {26'h0, m_mode};
      2'd1: return {26'h0, m_en};
      2'd2: return {26'h0, m_pend};
      default: return {found, 28'h0, idx};
    endcase
  endfunction

  // Advance one clock edge, updating the model from the inputs presented at that edge.
  task automatic step();
    logic [5:0] sy;
    logic [5:0] pv;
    logic [5:0] np;
    int n;
    n  = hist.size();
    sy = (n >= SYNC) ? hist[n-SYNC] : 6'h00;
    pv = (n >= SYNC + 1) ? hist[n-SYNC-1] : 6'h00;
    for (int i = 0; i < 6; i++) begin
      if (We && Addr == 2'd0 && WData[i] != m_mode[i])
        np[i] = 1'b0;
      else if (m_mode[i])
        np[i] = (sy[i] && !pv[i]) ? 1'b1 : ((We && Addr == 2'd2 && WData[i]) ? 1'b0 : m_pend[i]);
      else
        np[i] = sy[i];
    end
    @(posedge Clk);
    m_hw = m_pend & m_en;
    if (We && Addr == 2'd0) m_mode = WData[5:0];
    if (We && Addr == 2'd1) m_en = WData[5:0];
    m_pend = np;
    hist.push_back(IrqIn);
    if (hist.size() > SYNC + 1) void'(hist.pop_front());
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    Addr  = a;
    WData = d;
    We    = 1'b1;
    step();
    We    = 1'b0;
    WData = 32'h0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    m_reset();
    repeat (2) @(posedge Clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      Addr = 2'(a);
      #1;
      total++;
      if (RData !== 32'h0) begin
        bad++;
        $display("FAIL reset_rdata addr=%0d: got %h want 00000000", a, RData);
      end
    end
    total++;
    if (HWInt !== 6'h00) begin
      bad++;
      $display("FAIL reset_hwint: got %h want 00", HWInt);
    end
    Rst = 1'b0;
  endtask

  task automatic test_edge();
    bus_wr(2'd0, 32'h01);
    bus_wr(2'd1, 32'h01);
    IrqIn = 6'h01;
    step();
    IrqIn = 6'h00;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) step();
      total++;
      if (HWInt !== ((k >= 4) ? 6'h01 : 6'h00)) begin
        bad++;
        $display("FAIL edge_latency edge=%0d: got %h want %h", k, HWInt, (k >= 4) ? 6'h01 : 6'h00);
      end
    end
    Addr = 2'd3;
    #1;
    total++;
    if (RData !== 32'h8000_0000) begin
      bad++;
      $display("FAIL edge_status: got %h want 80000000", RData);
    end
    bus_wr(2'd2, 32'h01);
    total++;
    if (HWInt !== 6'h01) begin
      bad++;
      $display("FAIL w1c_same_edge: got %h want 01", HWInt);
    end
    step();
    total++;
    if (HWInt !== 6'h00) begin
      bad++;
      $display("FAIL w1c_next_edge: got %h want 00", HWInt);
    end
  endtask

  task automatic test_level();
    logic [5:0] want;
    bus_wr(2'd0, 32'h00);
    bus_wr(2'd1, 32'h08);
    for (int k = 1; k <= 16; k++) begin
      IrqIn = (k <= 10) ? 6'h08 : 6'h00;
      if (k == 6) begin
        bus_wr(2'd2, 32'h08);
      end else begin
        step();
      end
      want = (k >= 4 && k <= 13) ? 6'h08 : 6'h00;
      total++;
      if (HWInt !== want) begin
        bad++;
        $display("FAIL level_follow edge=%0d: got %h want %h", k, HWInt, want);
      end
    end
  endtask

  task automatic test_priority();
    bus_wr(2'd0, 32'h12);
    bus_wr(2'd1, 32'h12);
    IrqIn = 6'h12;
    step();
    IrqIn = 6'h00;
    repeat (4) step();
    Addr = 2'd3;
    #1;
    total++;
    if (RData !== 32'h8000_0001) begin
      bad++;
      $display("FAIL prio_both: got %h want 80000001", RData);
    end
    bus_wr(2'd2, 32'h02);
    step();
    Addr = 2'd3;
    #1;
    total++;
    if (RData !== 32'h8000_0004) begin
      bad++;
      $display("FAIL prio_after_clear: got %h want 80000004", RData);
    end
  endtask

  task automatic test_collide();
    bus_wr(2'd0, 32'h04);
    bus_wr(2'd1, 32'h04);
    IrqIn = 6'h04;
    step();
    IrqIn = 6'h00;
    repeat (4) step();
    IrqIn = 6'h04;
    step();
    IrqIn = 6'h00;
    step();
    bus_wr(2'd2, 32'h04);
    Addr = 2'd2;
    #1;
    total++;
    if (RData !== 32'h04) begin
      bad++;
      $display("FAIL set_beats_w1c: got %h want 00000004", RData);
    end
    bus_wr(2'd0, 32'h00);
    Addr = 2'd2;
    #1;
    total++;
    if (RData !== 32'h00) begin
      bad++;
      $display("FAIL mode_change_clear: got %h want 00000000", RData);
    end
  endtask

  task automatic test_mask();
    bus_wr(2'd1, 32'h00);
    bus_wr(2'd0, 32'h20);
    IrqIn = 6'h20;
    step();
    IrqIn = 6'h00;
    repeat (5) step();
    total++;
    if (HWInt !== 6'h00) begin
      bad++;
      $display("FAIL mask_hwint: got %h want 00", HWInt);
    end
    Addr = 2'd2;
    #1;
    total++;
    if (RData !== 32'h20) begin
      bad++;
      $display("FAIL mask_pending: got %h want 00000020", RData);
    end
    bus_wr(2'd1, 32'h20);
    total++;
    if (HWInt !== 6'h00) begin
      bad++;
      $display("FAIL enable_same_edge: got %h want 00", HWInt);
    end
    step();
    total++;
    if (HWInt !== 6'h20) begin
      bad++;
      $display("FAIL enable_next_edge: got %h want 20", HWInt);
    end
  endtask

  task automatic test_random();
    logic [31:0] want;
    for (int c = 0; c < 400; c++) begin
      IrqIn = 6'($urandom);
      Addr  = 2'($urandom);
      We    = ($urandom_range(0, 3) == 0);
      WData = $urandom;
      #1;
      want = exp_rd(Addr);
      total++;
      if (RData !== want) begin
        bad++;
        $display("FAIL rand_rdata cyc=%0d addr=%0d: got %h want %h", c, Addr, RData, want);
      end
      step();
      We = 1'b0;
      total++;
      if (HWInt !== m_hw) begin
        bad++;
        $display("FAIL rand_hwint cyc=%0d: got %h want %h", c, HWInt, m_hw);
      end
    end
    IrqIn = 6'h00;
    WData = 32'h0;
  endtask

  task automatic test_reset_mid();
    bus_wr(2'd0, 32'h3F);
    bus_wr(2'd1, 32'h3F);
    repeat (4) step();
    IrqIn = 6'h3F;
    step();
    IrqIn = 6'h00;
    repeat (4) step();
    total++;
    if (HWInt !== 6'h3F) begin
      bad++;
      $display("FAIL pre_reset_hwint: got %h want 3f", HWInt);
    end
    #2;
    Rst = 1'b1;
    #1;
    total++;
    if (HWInt !== 6'h00) begin
      bad++;
      $display("FAIL async_reset_hwint: got %h want 00", HWInt);
    end
    for (int a = 0; a < 4; a++) begin
      Addr = 2'(a);
      #1;
      total++;
      if (RData !== 32'h0) begin
        bad++;
        $display("FAIL async_reset_rdata addr=%0d: got %h want 00000000", a, RData);
      end
    end
    m_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b1;
    IrqIn = 6'h00;
    Addr  = 2'd0;
    We    = 1'b0;
    WData = 32'h0;
    m_reset();
    test_reset();
    test_edge();
    test_level();
    test_priority();
    test_collide();
    test_mask();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
